debug_controller: RTL and testbench
===================================

Name: debug_controller

Overview:
- Parametrised host-debug controller for the pipelined MIPS core. It drives a byte-stream UART: it consumes received bytes and issues transmit bytes to external rx/tx UART instances.
- Modes: program load into instruction memory, single step, free run until HALT, host-requested pause, and standalone dump.
- Each dump sends, in order: cycle counter, PC, every register-file word, every data-memory word.
- Sits between the UART pair and the core's debug ports and pipeline-enable.

Parameters:
- NB_DATA, 32, width of instruction/register/memory words.
- N_BYTES, NB_DATA/8, bytes per word on the serial link.
- NB_REG, 5, register-file address width.
- N_REGISTER, 32, registers dumped, addresses 0..N_REGISTER-1.
- NB_DADDR, 7, data-memory address width.
- N_MEMORY_DATA, 128, data words dumped, addresses 0..N_MEMORY_DATA-1.
- NB_IADDR, 7, instruction-memory address width.
- NB_PC, 7, PC width; zero-extended to NB_DATA when sent.
- HALT_WORD, 32'hFC000000, instruction word that ends a load.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle pulse; rx_data_i is valid while it is high.
- tx_data_o  out  8  byte to transmit.
- tx_start_o  out  1  one-cycle pulse that starts a UART transmit.
- tx_ready_i  in  1  level; high while the UART transmitter is idle.
- halt_i  in  1  core has retired HALT.
- pipe_en_o  out  1  pipeline enable.
- imem_we_o  out  1  instruction-memory write strobe.
- imem_addr_o  out  NB_IADDR  instruction-memory write address.
- imem_data_o  out  NB_DATA  instruction-memory write data.
- debug_sel_o  out  1  selects the debug address for the register-file and data-memory read ports.
- reg_addr_o  out  NB_REG  register read address.
- reg_data_i  in  NB_DATA  register read data, valid 1 cycle after the address.
- dmem_addr_o  out  NB_DADDR  data-memory read address.
- dmem_data_i  in  NB_DATA  data-memory read data, valid 1 cycle after the address.
- pc_i  in  NB_PC  current PC.
- state_o  out  4  encoded FSM state for the ILA.

Behaviour:
- Reset, asynchronous, takes effect at once. All outputs go to 0, state IDLE, cycle counter 0, load address 0.
  - Reset mid-load or mid-dump aborts the operation; no partial byte is re-sent.
- IDLE: a byte on rx_valid_i decodes as:
  - 0x01 -> LOAD
  - 0x02 -> STEP
  - 0x04 -> RUN
  - 0x10 -> DUMP
  - any other byte is ignored, state unchanged.
- LOAD, entry: imem_addr_o = 0 and cycle counter = 0.
- LOAD, byte assembly: bytes are assembled LSB first, shifting down as each byte arrives.
- LOAD, word write: after the N_BYTES-th byte, imem_we_o pulses for exactly 1 cycle with the assembled word. imem_addr_o increments in the following cycle.
- LOAD, exit: return to IDLE after writing a word equal to HALT_WORD, or after writing address 2^NB_IADDR-1. No wrap, so address 0 is never overwritten.
- STEP:
  - If halt_i=0, pipe_en_o is high for exactly 1 cycle, then DUMP.
  - If halt_i=1, pipe_en_o stays low and the block goes straight to DUMP.
- RUN, entry: pipe_en_o goes high the cycle after entry.
- RUN, exit: on halt_i=1, or on a received byte 0x20 (pause), pipe_en_o is low from the next cycle and the block goes to DUMP.
  - If both occur in the same cycle, it is treated as halt; the result is identical.
- Cycle counter: NB_DATA bits, increments on every clock with pipe_en_o=1, wraps modulo 2^NB_DATA.
- DUMP: debug_sel_o=1 for the whole dump, 0 elsewhere. pipe_en_o=0.
- DUMP word order:
  - cycle counter
  - zero-extended PC
  - reg[0..N_REGISTER-1]
  - dmem[0..N_MEMORY_DATA-1]
- DUMP word fetch: address is presented, 1 wait cycle, word is latched, then the word is sent as N_BYTES bytes, LSB first.
- DUMP total: N_BYTES*(2+N_REGISTER+N_MEMORY_DATA) bytes; 648 bytes at the defaults.
- DUMP exit: return to IDLE the cycle after the final tx_ready_i rise.
- TX handshake:
  - tx_start_o pulses only when tx_ready_i=1.
  - tx_data_o is stable from the pulse until tx_ready_i next rises.
  - tx_ready_i is ignored for the 1 cycle after the pulse.
  - The next byte may start no earlier than the cycle tx_ready_i is seen high again.
- rx bytes during STEP or DUMP, and rx bytes other than 0x20 during RUN, are dropped.

Decomposition:
- Shared package debug_pkg holds:
  - state encoding: IDLE, LOAD, STEP, RUN, DUMP_FETCH, DUMP_SEND, DUMP_WAIT
  - command byte constants: CMD_LOAD, CMD_STEP, CMD_RUN, CMD_DUMP, CMD_PAUSE
  - HALT_WORD default
- Sub-module debug_word_serializer: latches an NB_DATA word on a load pulse, runs the tx_start/tx_ready handshake for N_BYTES bytes, and raises done for 1 cycle.
- The top FSM sequences the word sources and owns the cycle counter and load path.

Test Plan:
- Load: send 0x01 then words 0x20010005 and 0xFC000000 LSB first. Expect imem_we_o pulses at addr 0 and addr 1 with those data, then IDLE, with no further writes on extra bytes.
- Load overflow: with NB_IADDR=2 send 0x01 then 6 non-HALT words. Expect exactly 4 writes at addrs 0..3, then IDLE; the remaining bytes are ignored.
- Step: with halt_i=0 send 0x02. Expect pipe_en_o high for exactly 1 cycle. The dump's first 4 bytes are 01 00 00 00 (counter=1), then the PC bytes, then reg and dmem words matching the models, 648 bytes total.
- Run: send 0x04, assert halt_i 37 cycles after pipe_en_o rises. Expect counter bytes 25 00 00 00 (37 decimal), pipe_en_o low, then a full dump, then IDLE.
- Pause: in RUN send 0x20. Expect pipe_en_o low within 1 cycle of rx_valid_i and a full dump; send 0x04 again and the counter resumes from its held value.
- Robustness:
  - Model a slow UART with tx_ready_i low for 10 cycles: expect never two tx_start_o pulses without an intervening tx_ready_i rise.
  - Assert reset_i mid-dump: expect all outputs 0 immediately and IDLE on release.
  - Send unknown byte 0x7F in IDLE: expect no state change.

Source files
------------

// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the host-debug controller: the top-level FSM state
// encoding (also exported on state_o for the ILA), the serializer's handshake
// states, the host command bytes and the default end-of-load instruction word.
// -----------------------------------------------------------------------------
package debug_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD       = 4'd1,
    STEP       = 4'd2,
    RUN        = 4'd3,
    DUMP_FETCH = 4'd4,  // dump address is on the read ports, data not yet valid
    DUMP_SEND  = 4'd5,  // read data valid: latch word and hand it to the serializer
    DUMP_WAIT  = 4'd6   // serializer is shifting the word out
  } state_t;

  typedef enum logic [2:0] {
    SER_IDLE  = 3'd0,
    SER_ISSUE = 3'd1,  // first byte: wait for an idle transmitter
    SER_PULSE = 3'd2,  // tx_start_o is high this cycle
    SER_HOLD  = 3'd3,  // tx_ready_i is not trusted yet
    SER_WAIT  = 3'd4   // wait for the transmitter to go idle again
  } ser_state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_STEP  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h04;
  localparam logic [7:0] CMD_DUMP  = 8'h10;
  localparam logic [7:0] CMD_PAUSE = 8'h20;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFC00_0000;

endpackage

// File: rtl/debug_controller_serializer.sv
// -----------------------------------------------------------------------------
// debug_word_serializer
// Latches an NB_DATA word on load_i and sends it LSB first as N_BYTES bytes
// over the tx_start/tx_ready handshake of a byte UART. done_o pulses for one
// cycle once the transmitter has gone idle after the last byte.
// Ports:
//   clock_i, reset_i   clock, asynchronous active-high reset
//   load_i, word_i     one-cycle load strobe and the word to send
//   tx_ready_i         transmitter idle level
//   tx_data_o          byte being sent, held until tx_ready_i rises again
//   tx_start_o         one-cycle transmit start
//   done_o             one-cycle completion pulse
// -----------------------------------------------------------------------------
module debug_word_serializer
  import debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_BYTES = NB_DATA / 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic               tx_ready_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  output logic               done_o
);

  localparam int NB_BCNT = $clog2(N_BYTES + 1);

  ser_state_t           ser_state_r;
  logic [NB_DATA-1:0]   shift_r;
  logic [NB_BCNT-1:0]   sent_r;
  logic [7:0]           tx_data_r;
  logic                 tx_start_r;
  logic                 done_r;

  // Byte handshake sequencer: start only on an idle transmitter, skip one
  // cycle after the start, then wait for the transmitter to report idle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ser_state_r <= SER_IDLE;
      shift_r     <= {NB_DATA{1'b0}};
      sent_r      <= {NB_BCNT{1'b0}};
      tx_data_r   <= 8'h00;
      tx_start_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
      case (ser_state_r)
        SER_IDLE: begin
          if (load_i) begin
            shift_r     <= word_i;
            sent_r      <= {NB_BCNT{1'b0}};
            ser_state_r <= SER_ISSUE;
          end
        end
        SER_ISSUE: begin
          if (tx_ready_i) begin
            tx_data_r   <= shift_r[7:0];
            shift_r     <= {8'h00, shift_r[NB_DATA-1:8]};
            tx_start_r  <= 1'b1;
            sent_r      <= sent_r + NB_BCNT'(1);
            ser_state_r <= SER_PULSE;
          end
        end
        SER_PULSE: ser_state_r <= SER_HOLD;
        SER_HOLD:  ser_state_r <= SER_WAIT;
        SER_WAIT: begin
          if (tx_ready_i) begin
            if (sent_r == NB_BCNT'(N_BYTES)) begin
              done_r      <= 1'b1;
              ser_state_r <= SER_IDLE;
            end else begin
              tx_data_r   <= shift_r[7:0];
              shift_r     <= {8'h00, shift_r[NB_DATA-1:8]};
              tx_start_r  <= 1'b1;
              sent_r      <= sent_r + NB_BCNT'(1);
              ser_state_r <= SER_PULSE;
            end
          end
        end
        default: ser_state_r <= SER_IDLE;
      endcase
    end
  end

  assign tx_data_o  = tx_data_r;
  assign tx_start_o = tx_start_r;
  assign done_o     = done_r;

endmodule

// File: rtl/debug_controller.sv
// -----------------------------------------------------------------------------
// debug_controller
// Host-debug controller for the pipelined MIPS core. Decodes host command
// bytes from the UART receiver, loads instruction memory, steps or runs the
// pipeline, and dumps cycle counter, PC, register file and data memory back
// through the UART transmitter.
// Ports:
//   clock_i, reset_i          clock, asynchronous active-high reset
//   rx_data_i, rx_valid_i     received byte and its one-cycle strobe
//   tx_data_o, tx_start_o     transmit byte and one-cycle start
//   tx_ready_i                transmitter idle level
//   halt_i                    core has retired HALT
//   pipe_en_o                 pipeline enable
//   imem_we_o/addr_o/data_o   instruction-memory write port
//   debug_sel_o               steer RF/DMEM read ports to the debug addresses
//   reg_addr_o, reg_data_i    register read port (1-cycle latency)
//   dmem_addr_o, dmem_data_i  data-memory read port (1-cycle latency)
//   pc_i                      current PC
//   state_o                   FSM state for the ILA
// -----------------------------------------------------------------------------
module debug_controller
  import debug_pkg::*;
#(
  parameter int                 NB_DATA       = 32,
  parameter int                 N_BYTES       = NB_DATA / 8,
  parameter int                 NB_REG        = 5,
  parameter int                 N_REGISTER    = 32,
  parameter int                 NB_DADDR      = 7,
  parameter int                 N_MEMORY_DATA = 128,
  parameter int                 NB_IADDR      = 7,
  parameter int                 NB_PC         = 7,
  parameter logic [NB_DATA-1:0] HALT_WORD     = NB_DATA'(DEFAULT_HALT_WORD)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic [7:0]          tx_data_o,
  output logic                tx_start_o,
  input  logic                tx_ready_i,
  input  logic                halt_i,
  output logic                pipe_en_o,
  output logic                imem_we_o,
  output logic [NB_IADDR-1:0] imem_addr_o,
  output logic [NB_DATA-1:0]  imem_data_o,
  output logic                debug_sel_o,
  output logic [NB_REG-1:0]   reg_addr_o,
  input  logic [NB_DATA-1:0]  reg_data_i,
  output logic [NB_DADDR-1:0] dmem_addr_o,
  input  logic [NB_DATA-1:0]  dmem_data_i,
  input  logic [NB_PC-1:0]    pc_i,
  output logic [3:0]          state_o
);

  localparam int N_WORDS = 2 + N_REGISTER + N_MEMORY_DATA;
  localparam int NB_IDX  = $clog2(N_WORDS);
  localparam int NB_BCNT = $clog2(N_BYTES + 1);

  state_t               state_r;
  logic [NB_DATA-1:0]   cycle_cnt_r;
  logic [NB_DATA-1:0]   asm_r;
  logic [NB_BCNT-1:0]   byte_cnt_r;
  logic                 imem_we_r;
  logic [NB_IADDR-1:0]  imem_addr_r;
  logic [NB_DATA-1:0]   imem_data_r;
  logic                 pipe_en_r;
  logic                 debug_sel_r;
  logic [NB_REG-1:0]    reg_addr_r;
  logic [NB_DADDR-1:0]  dmem_addr_r;
  logic [NB_IDX-1:0]    word_idx_r;
  logic                 ser_load_r;
  logic [NB_DATA-1:0]   ser_word_r;

  logic [NB_DATA-1:0]   asm_next_s;
  logic                 load_last_s;
  logic [NB_IDX-1:0]    next_idx_s;
  logic [NB_DATA-1:0]   word_sel_s;
  logic                 ser_done_s;

  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  assign asm_next_s  = {rx_data_i, asm_r[NB_DATA-1:8]};
  // Evaluated while the write strobe is high: stop on HALT or on the top address.
  assign load_last_s = (imem_data_r == HALT_WORD) || (imem_addr_r == {NB_IADDR{1'b1}});
  assign next_idx_s  = word_idx_r + NB_IDX'(1);

  // Dump word source for the current index; the PC is zero-extended.
  always_comb begin
    if (word_idx_r == NB_IDX'(0)) begin
      word_sel_s = cycle_cnt_r;
    end else if (word_idx_r == NB_IDX'(1)) begin
      word_sel_s = NB_DATA'(pc_i);
    end else if (word_idx_r < NB_IDX'(2 + N_REGISTER)) begin
      word_sel_s = reg_data_i;
    end else begin
      word_sel_s = dmem_data_i;
    end
  end

  // Main controller: command decode, load path, step/run control, dump sequencing.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      cycle_cnt_r <= {NB_DATA{1'b0}};
      asm_r       <= {NB_DATA{1'b0}};
      byte_cnt_r  <= {NB_BCNT{1'b0}};
      imem_we_r   <= 1'b0;
      imem_addr_r <= {NB_IADDR{1'b0}};
      imem_data_r <= {NB_DATA{1'b0}};
      pipe_en_r   <= 1'b0;
      debug_sel_r <= 1'b0;
      reg_addr_r  <= {NB_REG{1'b0}};
      dmem_addr_r <= {NB_DADDR{1'b0}};
      word_idx_r  <= {NB_IDX{1'b0}};
      ser_load_r  <= 1'b0;
      ser_word_r  <= {NB_DATA{1'b0}};
    end else begin
      imem_we_r  <= 1'b0;
      ser_load_r <= 1'b0;
      if (pipe_en_r) begin
        cycle_cnt_r <= cycle_cnt_r + NB_DATA'(1);
      end
      case (state_r)
        IDLE: begin
          if (rx_valid_i) begin
            case (rx_data_i)
              CMD_LOAD: begin
                state_r     <= LOAD;
                imem_addr_r <= {NB_IADDR{1'b0}};
                cycle_cnt_r <= {NB_DATA{1'b0}};
                byte_cnt_r  <= {NB_BCNT{1'b0}};
              end
              CMD_STEP: state_r <= STEP;
              CMD_RUN:  state_r <= RUN;
              CMD_DUMP: begin
                state_r     <= DUMP_FETCH;
                debug_sel_r <= 1'b1;
                word_idx_r  <= {NB_IDX{1'b0}};
                reg_addr_r  <= {NB_REG{1'b0}};
                dmem_addr_r <= {NB_DADDR{1'b0}};
              end
              default: state_r <= IDLE;
            endcase
          end
        end
        LOAD: begin
          if (imem_we_r && load_last_s) begin
            state_r <= IDLE;
          end else begin
            if (imem_we_r) begin
              imem_addr_r <= imem_addr_r + NB_IADDR'(1);
            end
            if (rx_valid_i) begin
              asm_r <= asm_next_s;
              if (byte_cnt_r == NB_BCNT'(N_BYTES - 1)) begin
                byte_cnt_r  <= {NB_BCNT{1'b0}};
                imem_we_r   <= 1'b1;
                imem_data_r <= asm_next_s;
              end else begin
                byte_cnt_r <= byte_cnt_r + NB_BCNT'(1);
              end
            end
          end
        end
        STEP: begin
          // One enabled cycle unless the core is already halted.
          if (pipe_en_r || halt_i) begin
            pipe_en_r   <= 1'b0;
            state_r     <= DUMP_FETCH;
            debug_sel_r <= 1'b1;
            word_idx_r  <= {NB_IDX{1'b0}};
            reg_addr_r  <= {NB_REG{1'b0}};
            dmem_addr_r <= {NB_DADDR{1'b0}};
          end else begin
            pipe_en_r <= 1'b1;
          end
        end
        RUN: begin
          if (halt_i || (rx_valid_i && (rx_data_i == CMD_PAUSE))) begin
            pipe_en_r   <= 1'b0;
            state_r     <= DUMP_FETCH;
            debug_sel_r <= 1'b1;
            word_idx_r  <= {NB_IDX{1'b0}};
            reg_addr_r  <= {NB_REG{1'b0}};
            dmem_addr_r <= {NB_DADDR{1'b0}};
          end else begin
            pipe_en_r <= 1'b1;
          end
        end
        DUMP_FETCH: state_r <= DUMP_SEND;
        DUMP_SEND: begin
          ser_word_r <= word_sel_s;
          ser_load_r <= 1'b1;
          state_r    <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (ser_done_s) begin
            if (word_idx_r == NB_IDX'(N_WORDS - 1)) begin
              state_r     <= IDLE;
              debug_sel_r <= 1'b0;
            end else begin
              word_idx_r <= next_idx_s;
              state_r    <= DUMP_FETCH;
              if ((next_idx_s >= NB_IDX'(2)) && (next_idx_s < NB_IDX'(2 + N_REGISTER))) begin
                reg_addr_r <= NB_REG'(next_idx_s - NB_IDX'(2));
              end
              if (next_idx_s >= NB_IDX'(2 + N_REGISTER)) begin
                dmem_addr_r <= NB_DADDR'(next_idx_s - NB_IDX'(2 + N_REGISTER));
              end
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .N_BYTES (N_BYTES)
  ) u_serializer (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (ser_load_r),
    .word_i     (ser_word_r),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_start_o (tx_start_o),
    .done_o     (ser_done_s)
  );

  assign pipe_en_o   = pipe_en_r;
  assign imem_we_o   = imem_we_r;
  assign imem_addr_o = imem_addr_r;
  assign imem_data_o = imem_data_r;
  assign debug_sel_o = debug_sel_r;
  assign reg_addr_o  = reg_addr_r;
  assign dmem_addr_o = dmem_addr_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: stimulus pushes expected UART bytes
// and instruction-memory writes into queues, monitors pop and compare.
module tb_debug_controller;

  localparam int NR      = 32;
  localparam int NM      = 128;
  localparam int N_WORDS = 2 + NR + NM;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_ready_i;
  logic        halt_i = 1'b0;
  logic        pipe_en_o;
  logic        imem_we_o;
  logic [1:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        debug_sel_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [6:0]  dmem_addr_o;
  logic [31:0] dmem_data_i;
  logic [6:0]  pc_i = 7'd0;
  logic [3:0]  state_o;

  debug_controller #(.NB_IADDR(2)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_ready_i(tx_ready_i), .halt_i(halt_i),
    .pipe_en_o(pipe_en_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o), .debug_sel_o(debug_sel_o), .reg_addr_o(reg_addr_o),
    .reg_data_i(reg_data_i), .dmem_addr_o(dmem_addr_o), .dmem_data_i(dmem_data_i),
    .pc_i(pc_i), .state_o(state_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [33:0] exp_wr_q[$];
  logic [31:0] reg_mem[NR];
  logic [31:0] dmem_mem[NM];
  logic [31:0] cnt_model = 32'd0;
  int pipe_hi_cnt = 0;
  int tx_delay = 4;
  int tx_busy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART transmitter model: busy for tx_delay cycles after each start.
  always @(posedge clock_i) begin
    if (reset_i) begin
      tx_ready_i <= 1'b1;
      tx_busy    <= 0;
    end else if (tx_start_o && tx_ready_i) begin
      tx_ready_i <= 1'b0;
      tx_busy    <= tx_delay;
    end else if (tx_busy > 1) begin
      tx_busy <= tx_busy - 1;
    end else if (tx_busy == 1) begin
      tx_busy    <= 0;
      tx_ready_i <= 1'b1;
    end
  end

  // Register file / data memory with one-cycle read latency.
  always @(posedge clock_i) begin
    reg_data_i  <= reg_mem[reg_addr_o];
    dmem_data_i <= dmem_mem[dmem_addr_o];
  end

  // Monitor: byte scoreboard, handshake rules, write scoreboard, pipe_en count.
  logic       prev_ready = 1'b1;
  logic       rise_seen = 1'b1;
  logic       wait_rise = 1'b0;
  logic [7:0] held_data = 8'h00;
  always @(negedge clock_i) begin
    if (reset_i) begin
      rise_seen = 1'b1;
      wait_rise = 1'b0;
    end else begin
      if (tx_ready_i && !prev_ready) begin
        rise_seen = 1'b1;
        if (wait_rise) begin
          check("tx_data_stable", {56'd0, tx_data_o}, {56'd0, held_data});
          wait_rise = 1'b0;
        end
      end
      if (tx_start_o) begin
        check("tx_handshake", {62'd0, rise_seen, tx_ready_i}, 64'd3);
        check("dump_sel", {62'd0, debug_sel_o, pipe_en_o}, 64'd2);
        rise_seen = 1'b0;
        wait_rise = 1'b1;
        held_data = tx_data_o;
        if (exp_q.size() == 0) begin
          check("unexpected_tx_byte", {56'd0, tx_data_o}, 64'hFFFF);
        end else begin
          check("tx_byte", {56'd0, tx_data_o}, {56'd0, exp_q.pop_front()});
        end
      end
      if (imem_we_o) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_imem_write", {30'd0, imem_addr_o, imem_data_o}, 64'hFFFF_FFFF_FFFF);
        end else begin
          check("imem_write", {30'd0, imem_addr_o, imem_data_o}, {30'd0, exp_wr_q.pop_front()});
        end
      end
      if (pipe_en_o) pipe_hi_cnt++;
    end
    prev_ready = tx_ready_i;
  end

  function automatic logic [7:0] safe_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h00 || b == 8'h01 || b == 8'h02 || b == 8'h04 || b == 8'h10 ||
        b == 8'h20 || b == 8'hFC) b = b ^ 8'h80;
    return b;
  endfunction

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge clock_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clock_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse_rx(b);
    repeat (3) @(negedge clock_i);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Expected dump stream: counter, PC, registers, data memory, each LSB first.
  task automatic push_dump(input logic [31:0] cnt);
    logic [31:0] w;
    for (int i = 0; i < N_WORDS; i++) begin
      if (i == 0) w = cnt;
      else if (i == 1) w = {25'd0, pc_i};
      else if (i < 2 + NR) w = reg_mem[i - 2];
      else w = dmem_mem[i - 2 - NR];
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(state_o == 4'd0 && exp_q.size() == 0 && debug_sel_o == 1'b0) && n < 30000) begin
      @(negedge clock_i);
      n++;
    end
    check(name, {63'd0, n >= 30000}, 64'd0);
  endtask

  task automatic wait_pipe_rise(input string name);
    int n = 0;
    while (!pipe_en_o && n < 20) begin
      @(negedge clock_i);
      n++;
    end
    check(name, {63'd0, pipe_en_o}, 64'd1);
  endtask

  initial begin
    logic [31:0] w;
    int k;
    int m;
    for (int i = 0; i < NR; i++) reg_mem[i] = $urandom();
    for (int i = 0; i < NM; i++) dmem_mem[i] = $urandom();

    // Reset state
    repeat (3) @(negedge clock_i);
    check("rst_outputs", {57'd0, tx_start_o, pipe_en_o, imem_we_o, debug_sel_o, state_o == 4'd0,
                          tx_data_o == 8'd0, imem_addr_o == 2'd0}, 64'h7);
    check("rst_buses", {imem_data_o, 20'd0, reg_addr_o, dmem_addr_o}, 64'd0);
    reset_i = 1'b0;
    @(negedge clock_i);

    // Unknown command ignored
    send_byte(8'h7F);
    check("unknown_cmd_state", {60'd0, state_o}, 64'd0);

    // Load two words ending in HALT; trailing unknown bytes cause no write
    exp_wr_q.push_back({2'd0, 32'h2001_0005});
    exp_wr_q.push_back({2'd1, HALT});
    send_byte(8'h01);
    send_word(32'h2001_0005);
    send_word(HALT);
    send_byte(8'hAA);
    send_byte(8'h55);
    check("load_state", {60'd0, state_o}, 64'd0);
    check("load_writes_done", {32'd0, exp_wr_q.size()}, 64'd0);

    // Load overflow: only addresses 0..3 written, rest ignored
    send_byte(8'h01);
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = safe_byte();
      if (i < 4) exp_wr_q.push_back({2'(i), w});
      send_word(w);
    end
    check("overflow_state", {60'd0, state_o}, 64'd0);
    check("overflow_writes_done", {32'd0, exp_wr_q.size()}, 64'd0);
    cnt_model = 32'd0;

    // Step with slow UART: one enabled cycle, counter 1
    tx_delay = 10;
    pc_i = 7'($urandom());
    pipe_hi_cnt = 0;
    cnt_model = cnt_model + 32'd1;
    push_dump(cnt_model);
    send_byte(8'h02);
    wait_idle("step_dump_timeout");
    check("step_pipe_cycles", pipe_hi_cnt, 64'd1);
    tx_delay = 4;

    // Zero the counter via a HALT-only load, then run until halt after 37 cycles
    exp_wr_q.push_back({2'd0, HALT});
    send_byte(8'h01);
    send_word(HALT);
    cnt_model = 32'd0;
    pc_i = 7'($urandom());
    pipe_hi_cnt = 0;
    push_dump(cnt_model + 32'd37);
    cnt_model = cnt_model + 32'd37;
    pulse_rx(8'h04);
    wait_pipe_rise("run_pipe_rise");
    repeat (36) @(negedge clock_i);
    halt_i = 1'b1;
    @(negedge clock_i);
    check("run_pipe_low_after_halt", {63'd0, pipe_en_o}, 64'd0);
    wait_idle("run_dump_timeout");
    halt_i = 1'b0;
    check("run_pipe_cycles", pipe_hi_cnt, 64'd37);

    // Pause after a random number of cycles
    k = $urandom_range(0, 30);
    pc_i = 7'($urandom());
    pipe_hi_cnt = 0;
    cnt_model = cnt_model + 32'(k + 1);
    push_dump(cnt_model);
    pulse_rx(8'h04);
    wait_pipe_rise("pause_pipe_rise");
    repeat (k) @(negedge clock_i);
    rx_data_i  = 8'h20;
    rx_valid_i = 1'b1;
    @(negedge clock_i);
    rx_valid_i = 1'b0;
    check("pause_pipe_low", {63'd0, pipe_en_o}, 64'd0);
    wait_idle("pause_dump_timeout");
    check("pause_pipe_cycles", pipe_hi_cnt, 64'(k + 1));

    // Resume: counter continues from held value
    m = $urandom_range(5, 40);
    pipe_hi_cnt = 0;
    cnt_model = cnt_model + 32'(m);
    push_dump(cnt_model);
    pulse_rx(8'h04);
    wait_pipe_rise("resume_pipe_rise");
    repeat (m - 1) @(negedge clock_i);
    halt_i = 1'b1;
    wait_idle("resume_dump_timeout");
    check("resume_pipe_cycles", pipe_hi_cnt, 64'(m));

    // Step while halted: no enable, counter unchanged
    pipe_hi_cnt = 0;
    push_dump(cnt_model);
    send_byte(8'h02);
    wait_idle("step_halted_timeout");
    halt_i = 1'b0;
    check("step_halted_pipe_cycles", pipe_hi_cnt, 64'd0);

    // Reset in the middle of a standalone dump
    push_dump(cnt_model);
    send_byte(8'h10);
    k = 0;
    while (exp_q.size() > 4 * N_WORDS - 25 && k < 5000) begin
      @(negedge clock_i);
      k++;
    end
    check("middump_progress", {63'd0, k >= 5000}, 64'd0);
    reset_i = 1'b1;
    #1;
    check("middump_reset_outputs", {58'd0, tx_start_o, pipe_en_o, imem_we_o, debug_sel_o,
                                    state_o == 4'd0, tx_data_o == 8'd0}, 64'h3);
    check("middump_reset_addrs", {20'd0, reg_addr_o, dmem_addr_o, imem_data_o}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    repeat (5) @(negedge clock_i);
    check("post_reset_idle", {59'd0, state_o, tx_start_o}, 64'd0);

    // Fresh dump after reset: counter cleared, stream restarts at byte 0
    cnt_model = 32'd0;
    pc_i = 7'($urandom());
    push_dump(cnt_model);
    send_byte(8'h10);
    wait_idle("final_dump_timeout");

    repeat (20) @(negedge clock_i);
    check("tx_queue_empty", {32'd0, exp_q.size()}, 64'd0);
    check("wr_queue_empty", {32'd0, exp_wr_q.size()}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
